// File: rtl/pending_encoder_pkg.sv
// pending_encoder_pkg: shared sizes and the one-hot helper used by the encoder and its 3-to-8 decoder.
package pending_encoder_pkg;
    localparam int N_DEF = 8;
    localparam int W_DEF = $clog2(N_DEF);

    function automatic logic [N_DEF-1:0] onehot(input logic [W_DEF-1:0] idx);
        return N_DEF'(1) << idx;
    endfunction
endpackage

// File: rtl/pending_encoder_if.sv
// pending_encoder_if: event inputs, index handshake and status outputs of the pending encoder.
interface pending_encoder_if #(parameter int N = 8, parameter int W = $clog2(N));
    logic [N-1:0] i;
    logic         ready;
    logic [W-1:0] o;
    logic         valid;
    logic [N-1:0] pending;
    logic         overflow;

    modport master (input i, ready, output o, valid, pending, overflow);
    modport slave  (output i, ready, input o, valid, pending, overflow);
endinterface

// File: rtl/pending_encoder_prio_enc.sv
// prio_enc: combinational lowest-set-bit encoder.
module prio_enc #(parameter int N = 8, parameter int W = $clog2(N)) (
    input  logic [N-1:0] req,
    output logic [W-1:0] idx,
    output logic         any
);
    always_comb begin
        idx = '0;
        for (int j = N - 1; j >= 0; j--)
            if (req[j]) idx = W'(j);
    end
    assign any = |req;
endmodule

// File: rtl/pending_encoder.sv
// pending_encoder: sticky event capture, emitted one index at a time, lowest first, over valid/ready.
module pending_encoder
    import pending_encoder_pkg::*;
#(parameter int N = N_DEF, parameter int W = $clog2(N)) (
    input logic              clk,
    input logic              rst,
    pending_encoder_if.master bus
);
    logic [N-1:0] cand;
    logic [W-1:0] k;
    logic         load;
    logic         any;

    assign cand = bus.pending | bus.i;
    assign load = !bus.valid || bus.ready;

    prio_enc #(.N(N), .W(W)) u_prio (.req(cand), .idx(k), .any(any));

    // An event matching the presented o is not a duplicate: only pending bits count as overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.o        <= '0;
            bus.valid    <= 1'b0;
            bus.pending  <= '0;
            bus.overflow <= 1'b0;
        end else begin
            bus.overflow <= |(bus.i & bus.pending);
            if (load) begin
                bus.valid   <= any;
                bus.pending <= cand & ~(N'(1) << k);
                if (any) bus.o <= k;
            end else begin
                bus.pending <= cand;
            end
        end
    end
endmodule

// File: tb/tb_pending_encoder.sv
// tb_pending_encoder: directed scenarios plus random traffic against a set-based reference model.
module tb_pending_encoder;
    import pending_encoder_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   vectors = 0;
    int   miscompares = 0;

    bit   m_set[8];
    int   m_o;
    bit   m_valid;
    bit   m_ovf;

    pending_encoder_if #(.N(8)) bus ();
    pending_encoder dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] m_pend();
        logic [7:0] r = '0;
        for (int j = 0; j < 8; j++) r[j] = m_set[j];
        return r;
    endfunction

    task automatic model(input logic [7:0] ev, input bit rdy, input bit r);
        bit dup = 0;
        int lowest = -1;
        if (r) begin
            foreach (m_set[j]) m_set[j] = 0;
            m_o = 0; m_valid = 0; m_ovf = 0;
            return;
        end
        for (int j = 0; j < 8; j++) begin
            if (ev[j] && m_set[j]) dup = 1;
            if (ev[j]) m_set[j] = 1;
        end
        m_ovf = dup;
        if (!m_valid || rdy) begin
            for (int j = 7; j >= 0; j--) if (m_set[j]) lowest = j;
            m_valid = (lowest >= 0);
            if (lowest >= 0) begin
                m_o = lowest;
                m_set[lowest] = 0;
            end
        end
    endtask

    task automatic step(input logic [7:0] ev, input bit rdy, input bit r = 0);
        bus.i = ev; bus.ready = rdy; rst = r;
        @(posedge clk);
        model(ev, rdy, r);
        #1;
        check("valid", 32'(bus.valid), 32'(m_valid));
        check("pending", 32'(bus.pending), 32'(m_pend()));
        check("overflow", 32'(bus.overflow), 32'(m_ovf));
        if (m_valid) check("o", 32'(bus.o), 32'(m_o));
    endtask

    initial begin
        bus.i = '0; bus.ready = 1'b0; rst = 1'b1;
        step(8'hFF, 1, 1);
        step(8'hFF, 1, 1);
        check("rst_o", 32'(bus.o), 0);
        check("rst_valid", 32'(bus.valid), 0);
        check("rst_pending", 32'(bus.pending), 0);

        step(8'h20, 1);
        check("single_o", 32'(bus.o), 5);
        check("single_valid", 32'(bus.valid), 1);
        step(8'h00, 1);
        check("single_drain", 32'(bus.valid), 0);

        step(8'h85, 1); check("burst_0", 32'(bus.o), 0);
        step(8'h00, 1); check("burst_2", 32'(bus.o), 2);
        step(8'h00, 1); check("burst_7", 32'(bus.o), 7);
        step(8'h00, 1); check("burst_end", 32'(bus.valid), 0);

        step(8'h12, 0);
        check("bp_o", 32'(bus.o), 1);
        check("bp_pending", 32'(bus.pending), 32'h10);
        step(8'h01, 0); check("bp_hold", 32'(bus.o), 1);
        step(8'h00, 1); check("bp_seq0", 32'(bus.o), 0);
        step(8'h00, 1); check("bp_seq4", 32'(bus.o), 4);
        step(8'h00, 1); check("bp_end", 32'(bus.valid), 0);

        step(8'h28, 0);
        check("ovf_pre_o", 32'(bus.o), 3);
        check("ovf_pre_pend", 32'(bus.pending), 32'h20);
        step(8'h28, 0);
        check("ovf_pulse", 32'(bus.overflow), 1);
        check("ovf_pend", 32'(bus.pending), 32'h28);
        step(8'h00, 0); check("ovf_clear", 32'(bus.overflow), 0);
        step(8'h00, 1); check("ovf_seq3", 32'(bus.o), 3);
        step(8'h00, 1); check("ovf_seq5", 32'(bus.o), 5);
        step(8'h00, 1); check("ovf_end", 32'(bus.valid), 0);

        step(8'h0F, 0);
        step(8'h00, 0, 1);
        check("midrst_valid", 32'(bus.valid), 0);
        check("midrst_o", 32'(bus.o), 0);
        check("midrst_pend", 32'(bus.pending), 0);
        step(8'h00, 1); check("midrst_stale", 32'(bus.valid), 0);

        for (int j = 0; j < 8; j++) begin
            logic [7:0] ev;
            ev = 8'(1) << j;
            step(ev, 1);
            check("roundtrip", 32'(onehot(bus.o)), 32'(ev));
        end
        step(8'h00, 1);

        for (int n = 0; n < 400; n++) begin
            logic [7:0] ev;
            ev = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'(1) << $urandom_range(0, 7);
            if ($urandom_range(0, 3) == 0) ev = '0;
            step(ev, 1'($urandom_range(0, 2) != 0), $urandom_range(0, 60) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
